accum_rca: RTL and testbench



---
 rtl/accum_rca.sv | 81 ++++++++
 tb/tb_accum_rca.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/accum_rca.sv
// accum_rca: COUNT-term ripple-carry accumulator with wrap/saturate overflow and valid/ready result handshake
module accum_rca #(
  parameter int IN_WIDTH = 8,
  parameter int WIDTH = 10,
  parameter int COUNT = 4,
  parameter bit SAT = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                in_valid,
  input  logic [IN_WIDTH-1:0] in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_ovf,
  input  logic                out_ready
);
  localparam int CW = $clog2(COUNT + 1);
  typedef enum logic {ACC, HOLD} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, out_data_q, out_data_d, b, sum;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, out_ovf_q, out_ovf_d;
  logic [WIDTH:0] c;
  assign b = WIDTH'(in_data);
  assign c[0] = 1'b0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i] = acc_q[i] ^ b[i] ^ c[i];
    assign c[i+1] = (acc_q[i] & b[i]) | (c[i] & (acc_q[i] ^ b[i]));
  end
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    out_data_d = out_data_q;
    out_ovf_d = out_ovf_q;
    if (clr) begin
      state_d = ACC;
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (state_q == ACC && in_valid) begin
      acc_d = (c[WIDTH] && SAT) ? '1 : sum;
      ovf_d = ovf_q | c[WIDTH];
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(COUNT - 1)) begin
        state_d = HOLD;
        out_data_d = acc_d;
        out_ovf_d = ovf_d;
      end
    end else if (state_q == HOLD && out_ready) begin
      state_d = ACC;
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      out_data_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      out_data_q <= out_data_d;
      out_ovf_q <= out_ovf_d;
    end
  end
  assign in_ready = !rst && state_q == ACC;
  assign out_valid = state_q == HOLD;
  assign out_data = out_data_q;
  assign out_ovf = out_ovf_q;
endmodule

// File: tb/tb_accum_rca.sv
// tb_accum_rca: table, directed and random checks of accum_rca against an arithmetic reference model
module tb_accum_rca;
  logic clk = 1'b0, rst = 1'b1, clr = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic [3:0] ir, ov, oo;
  logic [9:0] od0;
  logic [7:0] od1, od2, od3;
  int passed = 0, total = 0;
  int wd[4] = '{10, 8, 8, 8};
  int cn[4] = '{4, 4, 4, 1};
  bit st[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  bit hold[4], known[4], eo[4];
  longint tot[4], ed[4];
  int n[4];
  always #5 clk = ~clk;
  accum_rca #(.IN_WIDTH(8), .WIDTH(10), .COUNT(4), .SAT(1'b0)) u0 (.clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[0]), .out_valid(ov[0]), .out_data(od0), .out_ovf(oo[0]), .out_ready(out_ready));
  accum_rca #(.IN_WIDTH(8), .WIDTH(8), .COUNT(4), .SAT(1'b0)) u1 (.clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[1]), .out_valid(ov[1]), .out_data(od1), .out_ovf(oo[1]), .out_ready(out_ready));
  accum_rca #(.IN_WIDTH(8), .WIDTH(8), .COUNT(4), .SAT(1'b1)) u2 (.clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[2]), .out_valid(ov[2]), .out_data(od2), .out_ovf(oo[2]), .out_ready(out_ready));
  accum_rca #(.IN_WIDTH(8), .WIDTH(8), .COUNT(1), .SAT(1'b1)) u3 (.clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[3]), .out_valid(ov[3]), .out_data(od3), .out_ovf(oo[3]), .out_ready(out_ready));
  typedef struct {
    bit r, c, iv;
    int d;
    bit ordy, ev, chkd;
    int edata;
  } vec_t;
  vec_t tbl[11];
  function automatic longint od(int k);
    return k == 0 ? longint'(od0) : k == 1 ? longint'(od1) : k == 2 ? longint'(od2) : longint'(od3);
  endfunction
  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  task automatic model();
    longint lim;
    for (int k = 0; k < 4; k++) begin
      lim = longint'(1) << wd[k];
      if (rst) begin
        hold[k] = 0; tot[k] = 0; n[k] = 0; ed[k] = 0; eo[k] = 0; known[k] = 1;
      end else if (clr) begin
        hold[k] = 0; tot[k] = 0; n[k] = 0; known[k] = 0;
      end else if (!hold[k] && in_valid) begin
        tot[k] += longint'(in_data);
        n[k]++;
        if (n[k] == cn[k]) begin
          ed[k] = st[k] ? (tot[k] >= lim ? lim - 1 : tot[k]) : tot[k] % lim;
          eo[k] = tot[k] >= lim;
          hold[k] = 1; known[k] = 1; tot[k] = 0; n[k] = 0;
        end
      end else if (hold[k] && out_ready) begin
        hold[k] = 0; known[k] = 0;
      end
    end
  endtask
  task automatic step();
    model();
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("u%0d.out_valid", k), longint'(ov[k]), longint'(hold[k]));
      chk($sformatf("u%0d.in_ready", k), longint'(ir[k]), longint'(!rst && !hold[k]));
      if (known[k]) begin
        chk($sformatf("u%0d.out_data", k), od(k), ed[k]);
        chk($sformatf("u%0d.out_ovf", k), longint'(oo[k]), longint'(eo[k]));
      end
    end
  endtask
  task automatic drive(input bit r, input bit c, input bit iv, input int d, input bit o);
    rst = r; clr = c; in_valid = iv; in_data = 8'(d); out_ready = o;
    step();
  endtask
  initial begin
    tbl[0] = '{1, 0, 0, 0, 0, 0, 1, 0};
    tbl[1] = '{0, 0, 1, 3, 0, 0, 1, 0};
    tbl[2] = '{0, 0, 1, 5, 0, 0, 1, 0};
    tbl[3] = '{0, 0, 1, 7, 0, 0, 1, 0};
    tbl[4] = '{0, 0, 1, 9, 0, 1, 1, 24};
    tbl[5] = '{0, 0, 0, 0, 1, 0, 0, 0};
    tbl[6] = '{0, 0, 1, 1, 0, 0, 0, 0};
    tbl[7] = '{0, 0, 1, 1, 0, 0, 0, 0};
    tbl[8] = '{0, 0, 1, 1, 0, 0, 0, 0};
    tbl[9] = '{0, 0, 1, 1, 0, 1, 1, 4};
    tbl[10] = '{0, 0, 0, 0, 1, 0, 0, 0};
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].r, tbl[i].c, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      chk($sformatf("tbl%0d.out_valid", i), longint'(ov[0]), longint'(tbl[i].ev));
      if (tbl[i].chkd) chk($sformatf("tbl%0d.out_data", i), longint'(od0), longint'(tbl[i].edata));
    end
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 255, 0);
    chk("wrap.out_data", longint'(od1), 252);
    chk("wrap.out_ovf", longint'(oo[1]), 1);
    chk("sat.out_data", longint'(od2), 255);
    chk("sat.out_ovf", longint'(oo[2]), 1);
    chk("wide.out_data", longint'(od0), 1020);
    chk("wide.out_ovf", longint'(oo[0]), 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 1, 3, 0);
    drive(0, 0, 1, 5, 0);
    drive(0, 0, 1, 7, 0);
    drive(0, 0, 1, 9, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 1, 0);
      chk("bp.in_ready", longint'(ir[0]), 0);
      chk("bp.out_data", longint'(od0), 24);
    end
    drive(0, 0, 1, 1, 1);
    chk("bp.release_in_ready", longint'(ir[0]), 1);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 2, 0);
    chk("bp.next_sum", longint'(od0), 8);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 1, 10, 0);
    drive(0, 0, 1, 20, 0);
    drive(0, 1, 1, 99, 0);
    for (int i = 1; i <= 4; i++) drive(0, 0, 1, i, 0);
    chk("clr_mid.out_data", longint'(od0), 10);
    chk("clr_mid.out_valid", longint'(ov[0]), 1);
    drive(0, 1, 0, 0, 0);
    chk("clr_hold.out_valid", longint'(ov[0]), 0);
    drive(0, 0, 1, 50, 0);
    drive(1, 1, 1, 50, 1);
    chk("rst_clr.out_valid", longint'(ov[0]), 0);
    chk("rst_clr.out_data", longint'(od0), 0);
    chk("rst_clr.out_ovf", longint'(oo[0]), 0);
    chk("rst_clr.in_ready", longint'(ir[0]), 0);
    drive(0, 0, 1, 7, 0);
    drive(0, 0, 1, 7, 0);
    drive(1, 0, 1, 7, 0);
    chk("rst_mid.out_valid", longint'(ov[0]), 0);
    chk("rst_mid.out_data", longint'(od0), 0);
    chk("rst_mid.in_ready", longint'(ir[0]), 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 1, 0);
    chk("rst_mid.out_data_after", longint'(od0), 4);
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3, ($urandom % 4) != 0,
            ($urandom % 2) ? int'($urandom_range(200, 255)) : int'($urandom_range(0, 255)), ($urandom % 3) != 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
